mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: a decode FSM that sequences the datapath
// enables and mux selects, and counts retired instructions.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic [1:0]  EOp,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  NPCOp,
  output logic [2:0]  state,
  output logic [31:0] icnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] icnt_q, icnt_d;

  logic [5:0] opcode, funct;
  logic isAddu, isSubu, isJr, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;
  logic isAluOp, isJump;
  logic retire;
  logic pcWr, irWr, rfWr, dmWr;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // An all-zero word (nop) has funct 0 and therefore falls out as undefined.
  always_comb begin
    isAddu  = (opcode == 6'b000000) && (funct == 6'b100001);
    isSubu  = (opcode == 6'b000000) && (funct == 6'b100011);
    isJr    = (opcode == 6'b000000) && (funct == 6'b001000);
    isOri   = (opcode == 6'b001101);
    isLui   = (opcode == 6'b001111);
    isLw    = (opcode == 6'b100011);
    isSw    = (opcode == 6'b101011);
    isBeq   = (opcode == 6'b000100);
    isJ     = (opcode == 6'b000010);
    isJal   = (opcode == 6'b000011);
    isAluOp = isAddu | isSubu | isOri | isLui;
    isJump  = isJ | isJal | isJr;
  end

  always_comb begin
    state_d  = FETCH;
    retire   = 1'b0;
    pcWr     = 1'b0;
    irWr     = 1'b0;
    rfWr     = 1'b0;
    dmWr     = 1'b0;
    ALUOp    = 2'd0;
    ALUSrc   = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    NPCOp    = 2'd0;

    unique case (opcode)
      6'b001101: EOp = 2'd1;
      6'b001111: EOp = 2'd2;
      6'b000100: EOp = 2'd3;
      default:   EOp = 2'd0;
    endcase

    case (state_q)
      FETCH: begin
        irWr    = 1'b1;
        pcWr    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (isAluOp | isLw | isSw | isBeq) begin
          state_d = EXEC;
        end else begin
          state_d = FETCH;
          retire  = isJump;
          if (isJ | isJal) begin
            pcWr  = 1'b1;
            NPCOp = 2'd2;
          end
          if (isJal) begin
            rfWr     = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
          if (isJr) begin
            pcWr  = 1'b1;
            NPCOp = 2'd3;
          end
        end
      end
      EXEC: begin
        if (isSubu | isBeq) ALUOp = 2'd1;
        else if (isOri)     ALUOp = 2'd2;
        ALUSrc = isOri | isLui | isLw | isSw;
        if (isBeq) begin
          NPCOp   = 2'd1;
          pcWr    = zero;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (isLw | isSw) begin
          state_d = MEM;
        end else if (isAluOp) begin
          state_d = WB;
        end
      end
      MEM: begin
        if (isLw) begin
          state_d = WB;
        end else begin
          dmWr    = isSw;
          retire  = isSw;
          state_d = FETCH;
        end
      end
      WB: begin
        rfWr     = 1'b1;
        RegDst   = (isAddu | isSubu) ? 2'd1 : 2'd0;
        MemtoReg = isLw ? 2'd1 : 2'd0;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase

    icnt_d = icnt_q + {31'd0, retire};
  end

  // Reset masks every write enable immediately, not just from the next edge.
  assign PCWr = pcWr & ~reset;
  assign IRWr = irWr & ~reset;
  assign RFWr = rfWr & ~reset;
  assign DMWr = dmWr & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      icnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  assign state = state_q;
  assign icnt  = icnt_q;

endmodule
